// File: rtl/bank_sync_seq_pkg.sv
// Shared definitions for the bank sequencer: per-bank state codes and the
// sequencer state enum, also imported by the MEMSync top.
package bank_sync_seq_pkg;

    localparam logic [4:0] BANK_IDLE  = 5'b00000;
    localparam logic [4:0] BANK_WRITE = 5'b10010;
    localparam logic [4:0] BANK_READ  = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bank_sync_seq.sv
// Single-outstanding bank sequencer: accepts one read/write request, drives the
// target bank's state code for a fixed number of non-stalled cycles, then a GAP.
module bank_sync_seq
    import bank_sync_seq_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int WR_CYC    = 8,
    parameter int SYNC_AT   = 4,
    parameter int RD_CYC    = 3,
    localparam int BANKGROUPS    = 2**BGWIDTH,
    localparam int BANKSPERGROUP = 2**BAWIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [BGWIDTH-1:0]     req_bg,
    input  logic [BAWIDTH-1:0]     req_ba,
    input  logic [ADDRWIDTH-1:0]   req_row,
    input  logic                   stall,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0] RowId,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][4:0]           BankFSM,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                sync,
    output logic                   done,
    output seq_state_t             dbg_state
);

    localparam int CNT_W = $clog2(max_int(WR_CYC, RD_CYC) + 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] SYNC_IDX = CNT_W'(SYNC_AT);

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BGWIDTH-1:0]  bg_q;
    logic [BAWIDTH-1:0]  ba_q;
    logic                armed_q;
    logic                xfer;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and only from the first edge after reset.
    assign req_ready = armed_q && (state_q == ST_IDLE);
    assign xfer      = req_valid && req_ready;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = req_wr ? ST_WRITE : ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_WRITE: begin
                if (!stall) begin
                    if (cnt_q == WR_LAST) state_d = ST_GAP;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                if (!stall) begin
                    if (cnt_q == RD_LAST) state_d = ST_GAP;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
            if (xfer) begin
                bg_q <= req_bg;
                ba_q <= req_ba;
            end
        end
    end

    // Row registers keep their value once the bank goes idle again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RowId <= '0;
        end else if (xfer) begin
            RowId[req_bg][req_ba] <= req_row;
        end
    end

    // Sync follows the held counter, so a stall at SYNC_AT stretches one pulse.
    always_comb begin
        BankFSM = '0;
        sync    = '0;
        done    = 1'b0;
        case (state_q)
            ST_WRITE: begin
                BankFSM[bg_q][ba_q] = BANK_WRITE;
                sync[bg_q][ba_q]    = (cnt_q == SYNC_IDX);
            end
            ST_READ:  BankFSM[bg_q][ba_q] = BANK_READ;
            ST_GAP:   done = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_bank_sync_seq.sv
// Randomized bench for bank_sync_seq: each operation is expanded into a
// per-cycle expectation list from its length, sync index and stall plan.
`timescale 1ps/1ps
module tb_bank_sync_seq;
    import bank_sync_seq_pkg::*;

    localparam int BGW = 2;
    localparam int BAW = 2;
    localparam int AW  = 17;
    localparam int NBG = 4;
    localparam int NBA = 4;
    localparam int WR_N = 8;
    localparam int RD_N = 3;
    localparam int SYNC_I = 4;

    logic clk;
    logic reset_n;
    logic req_valid;
    logic req_ready;
    logic req_wr;
    logic [BGW-1:0] req_bg;
    logic [BAW-1:0] req_ba;
    logic [AW-1:0] req_row;
    logic stall;
    logic [NBG-1:0][NBA-1:0][AW-1:0] row_id;
    logic [NBG-1:0][NBA-1:0][4:0] bank_fsm;
    logic [NBG-1:0][NBA-1:0] sync;
    logic done;
    seq_state_t dbg_state;

    logic [AW-1:0] row_mem [NBG][NBA];
    int n_checks = 0;
    int n_pass = 0;

    bank_sync_seq #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW),
        .WR_CYC(WR_N), .SYNC_AT(SYNC_I), .RD_CYC(RD_N)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .stall(stall), .RowId(row_id), .BankFSM(bank_fsm), .sync(sync),
        .done(done), .dbg_state(dbg_state)
    );

    // clock (tCK = 750 ps)
    initial begin
        clk = 1'b0;
        forever #375 clk = ~clk;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic clear_rows();
        for (int g = 0; g < NBG; g++)
            for (int b = 0; b < NBA; b++)
                row_mem[g][b] = '0;
    endtask

    // rec layout: [7] stall to drive, [6] done, [5] sync, [4:0] code of target bank
    task automatic check_cycle(input logic [7:0] rec, input int tg, input int tb,
                               input logic exp_ready);
        for (int g = 0; g < NBG; g++) begin
            for (int b = 0; b < NBA; b++) begin
                logic tgt;
                tgt = (g == tg) && (b == tb);
                chk($sformatf("fsm[%0d][%0d]", g, b), 32'(bank_fsm[g][b]),
                    tgt ? 32'(rec[4:0]) : 32'd0);
                chk($sformatf("sync[%0d][%0d]", g, b), 32'(sync[g][b]),
                    tgt ? 32'(rec[5]) : 32'd0);
                chk($sformatf("row[%0d][%0d]", g, b), 32'(row_id[g][b]), 32'(row_mem[g][b]));
            end
        end
        chk("done", 32'(done), 32'(rec[6]));
        chk("ready", 32'(req_ready), 32'(exp_ready));
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input logic wr, input int bg, input int ba,
                          input logic [AW-1:0] row, input int stall_at, input int stall_len);
        logic [7:0] exp_q[$];
        logic [7:0] rec;
        logic [4:0] code;
        int n;
        int waited;
        n = wr ? WR_N : RD_N;
        code = wr ? 5'b10010 : 5'b01011;
        chk("ready_idle", 32'(req_ready), 32'd1);
        waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_cycle(8'h00, bg, ba, 1'b1);
        for (int k = 0; k < n; k++) begin
            int reps;
            reps = (k == stall_at) ? stall_len + 1 : 1;
            for (int r = 0; r < reps; r++)
                exp_q.push_back({(r < reps - 1), 1'b0, (wr && k == SYNC_I), code});
        end
        exp_q.push_back({1'($urandom_range(0, 1)), 1'b1, 1'b0, 5'b00000});
        req_valid = 1'b1;
        req_wr = wr;
        req_bg = BGW'(bg);
        req_ba = BAW'(ba);
        req_row = row;
        stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        row_mem[bg][ba] = row;
        while (exp_q.size() > 0) begin
            rec = exp_q.pop_front();
            check_cycle(rec, bg, ba, 1'b0);
            stall = rec[7];
            req_valid = 1'($urandom_range(0, 1));
            req_wr = 1'($urandom_range(0, 1));
            req_bg = BGW'($urandom_range(0, NBG - 1));
            req_ba = BAW'($urandom_range(0, NBA - 1));
            req_row = AW'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
        stall = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_bg = '0;
        req_ba = '0;
        req_row = '0;
        stall = 1'b0;
        clear_rows();

        #10;
        check_cycle(8'h00, 0, 0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #10;
        chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 32'd1);

        run_op(1'b1, 1, 2, 17'h1ABCD, -1, 0);
        run_op(1'b0, 0, 0, 17'd5, -1, 0);
        run_op(1'b1, 3, 1, AW'($urandom), 4, 3);
        run_op(1'b0, 2, 2, AW'($urandom), 1, 2);
        run_op(1'b1, 0, 3, AW'($urandom), 7, 1);

        // reset in write cycle 2: bank code drops at once, no sync, no done
        stall = 1'b0;
        req_valid = 1'b1;
        req_wr = 1'b1;
        req_bg = 2'd2;
        req_ba = 2'd1;
        req_row = 17'h0BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        row_mem[2][1] = 17'h0BEEF;
        check_cycle({3'b000, 5'b10010}, 2, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_cycle({3'b000, 5'b10010}, 2, 1, 1'b0);
        #100;
        reset_n = 1'b0;
        #10;
        clear_rows();
        check_cycle(8'h00, 2, 1, 1'b0);
        @(negedge clk);
        check_cycle(8'h00, 2, 1, 1'b0);
        reset_n = 1'b1;
        #10;
        check_cycle(8'h00, 2, 1, 1'b0);
        @(negedge clk);
        check_cycle(8'h00, 2, 1, 1'b1);
        run_op(1'b1, 2, 1, AW'($urandom), -1, 0);
        run_op(1'b1, 2, 1, AW'($urandom), SYNC_I, 2);

        for (int pass = 0; pass < 2; pass++) begin
            for (int g = 0; g < NBG; g++) begin
                for (int b = 0; b < NBA; b++) begin
                    logic w;
                    int sa;
                    w = (pass == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    sa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (w ? WR_N : RD_N) - 1) : -1;
                    run_op(w, g, b, AW'($urandom), sa, $urandom_range(0, 3));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bank_sync_seq.md
BANK_SYNC_SEQ -- requirements
Module: bank_sync_seq

Interface
REQ-001 Parameter BGWIDTH, default 2, bank-group address width; BANKGROUPS = 2**BGWIDTH.
REQ-002 Parameter BAWIDTH, default 2, bank address width; BANKSPERGROUP = 2**BAWIDTH.
REQ-003 Parameter ADDRWIDTH, default 17, row address width.
REQ-004 Parameter WR_CYC, default 8, cycles BankFSM holds the write code per write.
REQ-005 Parameter SYNC_AT, default 4, write cycle index (0-based) at which sync pulses; legal range 1..WR_CYC-1.
REQ-006 Parameter RD_CYC, default 3, cycles BankFSM holds the read code per read.
REQ-007 clk  input  1  single clock, all state rising-edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 req_valid  input  1  request offered.
REQ-010 req_ready  output  1  high when a request is accepted this cycle.
REQ-011 req_wr  input  1  1 = write, 0 = read.
REQ-012 req_bg  input  BGWIDTH  target bank group.
REQ-013 req_ba  input  BAWIDTH  target bank.
REQ-014 req_row  input  ADDRWIDTH  target row.
REQ-015 stall  input  1  back-pressure from the MEMSync top; freezes sequencing.
REQ-016 RowId  output  [BANKGROUPS][BANKSPERGROUP] x ADDRWIDTH  per-bank row.
REQ-017 BankFSM  output  [BANKGROUPS][BANKSPERGROUP] x 5  per-bank state code.
REQ-018 sync  output  [BANKGROUPS][BANKSPERGROUP] x 1  per-bank allocate-exit pulse.
REQ-019 done  output  1  one-cycle pulse when an operation completes.

Function
REQ-020 FSM states: IDLE, WRITE, READ, GAP; one operation outstanding at a time.
REQ-021 req_ready is high only in IDLE; a transfer occurs when req_valid && req_ready at a rising edge.
REQ-022 On transfer, bg/ba/row/wr are registered; the target BankFSM drives 5'b10010 (write) or 5'b01011 (read) and RowId drives req_row from the next cycle.
REQ-023 WRITE holds for WR_CYC non-stalled cycles; sync[bg][ba] is high for exactly one cycle, the cycle whose count index equals SYNC_AT.
REQ-024 READ holds for RD_CYC non-stalled cycles; sync stays 0.
REQ-025 After WRITE or READ, GAP lasts one cycle with BankFSM[bg][ba]=0, done=1, then IDLE.
REQ-026 While stall=1 in WRITE or READ, the cycle counter, state and all outputs hold; a sync pulse that coincides with stall is extended until the first non-stalled cycle, and still counts as one pulse.
REQ-027 stall is ignored in IDLE and GAP.
REQ-028 Non-targeted banks: BankFSM=0, sync=0; RowId retains its last driven value.
REQ-029 Counter width is $clog2(max(WR_CYC,RD_CYC)+1); counter resets to 0 on every transfer.
REQ-030 A request to the same bank as the previous one is legal; it starts no earlier than the cycle after GAP.

Reset
REQ-031 reset_n=0 forces, asynchronously, state=IDLE, counter=0, all BankFSM=0, all RowId=0, all sync=0, done=0, req_ready=0.
REQ-032 req_ready rises the first rising edge after reset_n deasserts.
REQ-033 Reset mid-WRITE/READ aborts the operation with no done pulse and no sync pulse.

Structure
REQ-034 A shared package holds BankFSM codes (IDLE=5'b00000, WRITE=5'b10010, READ=5'b01011) and the state enum; MEMSyncTop and this block both import it.
REQ-035 No sub-module required; the hold counter is inline.

Verification (tCK 0.75 ns, defaults)
REQ-036 Reset 1 tCK then release -> all outputs 0 during reset; req_ready=1 on the first edge after release.
REQ-037 Write bg=1 ba=2 row=0x1ABCD -> BankFSM[1][2]=5'b10010 for 8 cycles, RowId[1][2]=0x1ABCD, sync[1][2] high only at cycle 4, then 1 GAP cycle with done=1.
REQ-038 Read bg=0 ba=0 row=5 -> BankFSM[0][0]=5'b01011 for 3 cycles, sync 0 throughout, done on the 4th cycle.
REQ-039 Write with stall=1 for 3 cycles starting at cycle 4 -> sync held 3 extra cycles, total write 11 cycles, single done.
REQ-040 reset_n=0 at write cycle 2 -> BankFSM immediately 0, no sync, no done; next request after release runs normally.
REQ-041 Back-to-back write/read on all 16 banks with random rows -> each bank sees exact code/length sequence; other banks stay 0.
